motor_drive_ctrl: RTL and testbench
===================================

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  system clock; all logic rising-edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: en  input  1  rider drive enable, synchronous.
REQ-004 SHALL provide: target_mag  input  12  requested drive magnitude, unsigned.
REQ-005 SHALL provide: brake_lever_n  input  1  raw brake lever, active-low, asynchronous.
REQ-006 SHALL provide: hallGrn, hallYlw, hallBlu  input  1 each  raw hall sensors, asynchronous.
REQ-007 SHALL provide: PWM_synch  input  1  one-clk pulse per PWM period.
REQ-008 SHALL provide: clr_fault  input  1  fault clear pulse.
REQ-009 SHALL provide: drv_mag  output  12  magnitude to commutator, registered.
REQ-010 SHALL provide: brake_n  output  1  regen brake command to commutator, active-low, registered.
REQ-011 SHALL provide: state  output  3  IDLE=0, RAMP=1, RUN=2, BRAKE=3, FAULT=4.
REQ-012 SHALL provide: fault  output  1  high in FAULT; fault_code  output  2  01 stall, 10 invalid hall, 11 sequence error.
REQ-013 SHALL provide parameters: RAMP_STEP, default 12'd16, max drv_mag change per PWM period; STALL_MAG, default 12'h100, stall-check threshold; STALL_PERIODS, default 16'd2000, stall timeout in PWM periods.

Function
REQ-014 SHALL double-flop brake_lever_n and the three hall inputs; all decisions use synchronized values only.
REQ-015 SHALL sample synchronized hall code {G,Y,B} only on PWM_synch cycles; eff_target = en ? target_mag : 0.
REQ-016 SHALL apply priority per clk: fault detection > synchronized brake low > normal transitions.
REQ-017 SHALL transition IDLE->RAMP when en=1 and target_mag!=0; otherwise hold IDLE with drv_mag=0.
REQ-018 SHALL, in RAMP on each PWM_synch, move drv_mag toward eff_target by min(RAMP_STEP, |eff_target-drv_mag|); never overshoot, never wrap.
REQ-019 SHALL transition RAMP->RUN when drv_mag==eff_target and eff_target!=0; RAMP->IDLE when drv_mag==0 and en=0.
REQ-020 SHALL transition RUN->RAMP on the clk after eff_target!=drv_mag; drv_mag holds in RUN.
REQ-021 SHALL, from IDLE/RAMP/RUN with synchronized brake low, enter BRAKE with drv_mag=0 and brake_n=0 on the next edge (3 clk edges lever-to-output).
REQ-022 SHALL, in BRAKE, transition to IDLE (brake_n=1, drv_mag=0) when synchronized brake returns high; ramp restarts from 0.
REQ-023 SHALL count PWM_synch pulses in RAMP/RUN while drv_mag>=STALL_MAG and hall code unchanged; counter clears on hall change, condition false, or state exit; reaching STALL_PERIODS -> FAULT, code 01.
REQ-024 SHALL enter FAULT, code 10, after 3 consecutive PWM_synch samples of 000 or 111 in RAMP/RUN; a valid sample clears the count.
REQ-025 SHALL, in FAULT, drive drv_mag=0, brake_n=1 (coast), fault=1; exit to IDLE only when clr_fault=1 and en=0 in the same clk; fault_code clears on exit.
REQ-026 SHALL keep a prev_hall valid flag cleared in IDLE/BRAKE/FAULT; the first sample after entering RAMP only loads prev_hall.
REQ-027 SHALL ignore brake while in FAULT; clr_fault outside FAULT has no effect.

Reset
REQ-028 SHALL on rst_n low force immediately: state=IDLE, drv_mag=0, brake_n=1, fault=0, fault_code=00, all counters, sync flops and prev_hall valid flag =0.
REQ-029 SHALL, on reset mid-ramp or mid-brake, resume only via IDLE->RAMP from drv_mag=0.

Configuration
REQ-030 SHALL, with HALL_SEQ_CHECK_EN defined, enter FAULT code 11 when a valid hall sample differs from valid prev_hall and is not adjacent in 101-100-110-010-011-001 (either direction, wrapping).
REQ-031 SHALL, without HALL_SEQ_CHECK_EN, accept any valid-code transition; code 11 never produced.

Verification
REQ-032 SHALL cover: en=1, target=12'h040, PWM_synch every 8 clk -> drv_mag 16,32,48,64 on successive pulses, then state=RUN.
REQ-033 SHALL cover: RUN at 12'h200, brake_lever_n low -> 3 edges later brake_n=0, drv_mag=0, state=BRAKE; release -> IDLE, then ramp from 0.
REQ-034 SHALL cover: RUN at 12'h200, hall frozen at 101 with STALL_PERIODS=4 -> FAULT code 01 on 4th pulse; clr_fault with en=1 ignored; with en=0 -> IDLE.
REQ-035 SHALL cover: hall 111 for 3 PWM_synch in RUN -> FAULT code 10; 2 samples then 101 -> no fault.
REQ-036 SHALL cover: HALL_SEQ_CHECK_EN defined, hall 101->110 in RUN -> FAULT code 11; undefined -> stays RUN.
REQ-037 SHALL cover: rst_n asserted mid-ramp at drv_mag=12'h030 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/motor_drive_ctrl_if.sv
// Rider/commutator-side signal bundle for motor_drive_ctrl.
// master drives the rider, lever and hall inputs; slave is the controller.
interface motor_drive_ctrl_if;
  logic        en;
  logic [11:0] target_mag;
  logic        brake_lever_n;
  logic        hallGrn;
  logic        hallYlw;
  logic        hallBlu;
  logic        PWM_synch;
  logic        clr_fault;
  logic [11:0] drv_mag;
  logic        brake_n;
  logic [2:0]  state;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    output en, target_mag, brake_lever_n, hallGrn, hallYlw, hallBlu, PWM_synch, clr_fault,
    input  drv_mag, brake_n, state, fault, fault_code
  );

  modport slave (
    input  en, target_mag, brake_lever_n, hallGrn, hallYlw, hallBlu, PWM_synch, clr_fault,
    output drv_mag, brake_n, state, fault, fault_code
  );
endinterface

// File: rtl/motor_drive_ctrl.sv
// Motor drive controller: synchronized brake/hall inputs, slew-limited drive magnitude, stall/hall faults.
// Define HALL_SEQ_CHECK_EN to also fault (code 11) on out-of-order hall commutation.
module motor_drive_ctrl #(
  parameter logic [11:0] RAMP_STEP     = 12'd16,
  parameter logic [11:0] STALL_MAG     = 12'h100,
  parameter logic [15:0] STALL_PERIODS = 16'd2000
) (
  input logic               clk,
  input logic               rst_n,
  motor_drive_ctrl_if.slave mdc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    BRAKE = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_STALL   = 2'b01;
  localparam logic [1:0] FC_INVALID = 2'b10;
  localparam logic [1:0] FC_SEQ     = 2'b11;

  logic [1:0]  r_brake_sync;
  logic [2:0]  r_hall_s1;
  logic [2:0]  r_hall_s2;
  state_t      r_state;
  logic [11:0] r_drv_mag;
  logic        r_brake_n;
  logic [1:0]  r_fault_code;
  logic [2:0]  r_prev_hall;
  logic        r_prev_vld;
  logic [15:0] r_stall_cnt;
  logic [1:0]  r_inv_cnt;

  state_t      w_state_nxt;
  logic [11:0] w_mag_nxt;
  logic        w_brake_n_nxt;
  logic [1:0]  w_code_nxt;
  logic [2:0]  w_prev_hall_nxt;
  logic        w_prev_vld_nxt;
  logic [15:0] w_stall_cnt_nxt;
  logic [1:0]  w_inv_cnt_nxt;
  logic        w_fault_det;
  logic [1:0]  w_fault_code_det;
  logic [11:0] w_target_eff;
  logic [11:0] w_diff;
  logic [11:0] w_step;
  logic        w_active;
  logic        w_hall_vld;
  logic        w_brake_lo;

`ifdef HALL_SEQ_CHECK_EN
  function automatic logic [2:0] hall_pos(input logic [2:0] h);
    case (h)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  // Neighbours in the six-step ring are one position apart, or five across the wrap.
  function automatic logic hall_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] pa;
    logic [2:0] pb;
    logic [2:0] d;
    pa = hall_pos(a);
    pb = hall_pos(b);
    d  = (pa >= pb) ? (pa - pb) : (pb - pa);
    return (d == 3'd1) || (d == 3'd5);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brake_sync <= 2'b00;
      r_hall_s1    <= 3'b000;
      r_hall_s2    <= 3'b000;
    end else begin
      r_brake_sync <= {r_brake_sync[0], mdc.brake_lever_n};
      r_hall_s1    <= {mdc.hallGrn, mdc.hallYlw, mdc.hallBlu};
      r_hall_s2    <= r_hall_s1;
    end
  end

  assign w_brake_lo   = ~r_brake_sync[1];
  assign w_target_eff = mdc.en ? mdc.target_mag : 12'd0;
  assign w_active     = (r_state == RAMP) || (r_state == RUN);
  assign w_hall_vld   = (r_hall_s2 != 3'b000) && (r_hall_s2 != 3'b111);
  assign w_diff       = (w_target_eff >= r_drv_mag) ? (w_target_eff - r_drv_mag) : (r_drv_mag - w_target_eff);
  assign w_step       = (w_diff > RAMP_STEP) ? RAMP_STEP : w_diff;

  // Hall supervision: only PWM-aligned samples taken while driving count.
  always_comb begin
    w_stall_cnt_nxt  = r_stall_cnt;
    w_inv_cnt_nxt    = r_inv_cnt;
    w_prev_hall_nxt  = r_prev_hall;
    w_prev_vld_nxt   = r_prev_vld;
    w_fault_det      = 1'b0;
    w_fault_code_det = FC_NONE;
    if (!w_active) begin
      w_stall_cnt_nxt = 16'd0;
      w_inv_cnt_nxt   = 2'd0;
      w_prev_vld_nxt  = 1'b0;
    end else begin
      if (r_drv_mag < STALL_MAG) w_stall_cnt_nxt = 16'd0;
      if (mdc.PWM_synch) begin
        if (!w_hall_vld) begin
          w_stall_cnt_nxt = 16'd0;
          w_inv_cnt_nxt   = r_inv_cnt + 2'd1;
          if (r_inv_cnt == 2'd2) begin
            w_fault_det      = 1'b1;
            w_fault_code_det = FC_INVALID;
          end
        end else begin
          w_inv_cnt_nxt   = 2'd0;
          w_prev_hall_nxt = r_hall_s2;
          w_prev_vld_nxt  = 1'b1;
          if (r_prev_vld && (r_hall_s2 == r_prev_hall) && (r_drv_mag >= STALL_MAG)) begin
            w_stall_cnt_nxt = r_stall_cnt + 16'd1;
            if ((r_stall_cnt + 16'd1) == STALL_PERIODS) begin
              w_fault_det      = 1'b1;
              w_fault_code_det = FC_STALL;
            end
          end else begin
            w_stall_cnt_nxt = 16'd0;
          end
`ifdef HALL_SEQ_CHECK_EN
          if (r_prev_vld && (r_hall_s2 != r_prev_hall) && !hall_adjacent(r_hall_s2, r_prev_hall)) begin
            w_fault_det      = 1'b1;
            w_fault_code_det = FC_SEQ;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mag_nxt     = r_drv_mag;
    w_brake_n_nxt = r_brake_n;
    w_code_nxt    = r_fault_code;
    if (w_fault_det) begin
      w_state_nxt   = FAULT;
      w_mag_nxt     = 12'd0;
      w_brake_n_nxt = 1'b1;
      w_code_nxt    = w_fault_code_det;
    end else if (w_brake_lo && ((r_state == IDLE) || w_active)) begin
      w_state_nxt   = BRAKE;
      w_mag_nxt     = 12'd0;
      w_brake_n_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_mag_nxt     = 12'd0;
          w_brake_n_nxt = 1'b1;
          if (mdc.en && (mdc.target_mag != 12'd0)) w_state_nxt = RAMP;
        end
        RAMP: begin
          if ((r_drv_mag == w_target_eff) && (w_target_eff != 12'd0)) begin
            w_state_nxt = RUN;
          end else if ((r_drv_mag == 12'd0) && !mdc.en) begin
            w_state_nxt = IDLE;
          end else if (mdc.PWM_synch) begin
            w_mag_nxt = (w_target_eff > r_drv_mag) ? (r_drv_mag + w_step) : (r_drv_mag - w_step);
          end
        end
        RUN: begin
          if (w_target_eff != r_drv_mag) w_state_nxt = RAMP;
        end
        BRAKE: begin
          w_mag_nxt = 12'd0;
          if (!w_brake_lo) begin
            w_state_nxt   = IDLE;
            w_brake_n_nxt = 1'b1;
          end
        end
        FAULT: begin
          w_mag_nxt     = 12'd0;
          w_brake_n_nxt = 1'b1;
          if (mdc.clr_fault && !mdc.en) begin
            w_state_nxt = IDLE;
            w_code_nxt  = FC_NONE;
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_mag_nxt     = 12'd0;
          w_brake_n_nxt = 1'b1;
          w_code_nxt    = FC_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_drv_mag    <= 12'd0;
      r_brake_n    <= 1'b1;
      r_fault_code <= FC_NONE;
      r_prev_hall  <= 3'b000;
      r_prev_vld   <= 1'b0;
      r_stall_cnt  <= 16'd0;
      r_inv_cnt    <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_drv_mag    <= w_mag_nxt;
      r_brake_n    <= w_brake_n_nxt;
      r_fault_code <= w_code_nxt;
      r_prev_hall  <= w_prev_hall_nxt;
      r_prev_vld   <= w_prev_vld_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_inv_cnt    <= w_inv_cnt_nxt;
    end
  end

  assign mdc.drv_mag    = r_drv_mag;
  assign mdc.brake_n    = r_brake_n;
  assign mdc.state      = r_state;
  assign mdc.fault      = (r_state == FAULT);
  assign mdc.fault_code = r_fault_code;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: directed scenarios plus randomized ramp traffic against a pulse-level model.
module tb_motor_drive_ctrl;
  localparam int S_IDLE  = 0;
  localparam int S_RAMP  = 1;
  localparam int S_RUN   = 2;
  localparam int S_BRAKE = 3;
  localparam int S_FAULT = 4;
  localparam int STEP    = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [2:0] seq [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  int   hidx;

  int   m_st;
  int   m_mag;
  logic m_en;
  int   m_tgt;

  motor_drive_ctrl_if u_if();

  motor_drive_ctrl #(
    .RAMP_STEP    (12'd16),
    .STALL_MAG    (12'h100),
    .STALL_PERIODS(16'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mdc  (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_hall_code(input logic [2:0] h);
    {u_if.hallGrn, u_if.hallYlw, u_if.hallBlu} = h;
  endtask

  function automatic int eff();
    return m_en ? m_tgt : 0;
  endfunction

  // Settled controller mode implied by the current command and magnitude.
  task automatic settle();
    int e;
    e = eff();
    case (m_st)
      S_IDLE: if (m_en && m_tgt != 0) m_st = S_RAMP;
      S_RUN:  if (e != m_mag) m_st = S_RAMP;
      S_RAMP: begin
        if (m_mag == e && e != 0) m_st = S_RUN;
        else if (m_mag == 0 && !m_en) m_st = S_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic set_cmd(input logic e, input int t);
    u_if.en = e;
    u_if.target_mag = t[11:0];
    m_en = e;
    m_tgt = t;
    settle();
  endtask

  task automatic pwm(input int rot, input int gap, input bit check);
    int d;
    if (rot != 0) begin
      hidx = (hidx + rot + 6) % 6;
      set_hall_code(seq[hidx]);
    end
    clks(gap);
    u_if.PWM_synch = 1'b1;
    @(negedge clk);
    u_if.PWM_synch = 1'b0;
    if (check) begin
      if (m_st == S_RAMP) begin
        d = eff() - m_mag;
        if (d > STEP) d = STEP;
        else if (d < -STEP) d = -STEP;
        m_mag = m_mag + d;
      end
      settle();
      chk("pwm_mag", u_if.drv_mag, m_mag);
      clks(2);
      chk("pwm_state", u_if.state, m_st);
    end
  endtask

  task automatic ramp_to_run();
    for (int i = 0; i < 80 && m_st != S_RUN; i++) pwm(1, 7, 1);
    chk("ramp_reached_run", u_if.state, S_RUN);
  endtask

  task automatic pulse_clr();
    u_if.clr_fault = 1'b1;
    @(negedge clk);
    u_if.clr_fault = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, u_if.state, S_IDLE);
    chk({tag, "_mag"}, u_if.drv_mag, 0);
    chk({tag, "_brake_n"}, u_if.brake_n, 1);
    chk({tag, "_fault"}, u_if.fault, 0);
    chk({tag, "_code"}, u_if.fault_code, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    u_if.en = 1'b0;
    u_if.target_mag = 12'd0;
    u_if.brake_lever_n = 1'b1;
    u_if.PWM_synch = 1'b0;
    u_if.clr_fault = 1'b0;
    hidx = 0;
    set_hall_code(seq[0]);
    m_st = S_IDLE; m_mag = 0; m_en = 1'b0; m_tgt = 0;

    clks(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    clks(6);
    chk("post_reset_state", u_if.state, S_IDLE);
    chk("post_reset_brake_n", u_if.brake_n, 1);

    // Ramp to 0x40 in four 16-count steps, then RUN.
    set_cmd(1'b1, 12'h040);
    for (int i = 1; i <= 4; i++) begin
      pwm(1, 7, 1);
      chk("ramp40_mag", u_if.drv_mag, 16 * i);
    end
    chk("ramp40_run", u_if.state, S_RUN);

    // Ramp down to 0x30, then asynchronous reset mid-ramp.
    set_cmd(1'b0, 12'h040);
    pwm(1, 7, 1);
    chk("rampdn_mag", u_if.drv_mag, 12'h030);
    chk("rampdn_state", u_if.state, S_RAMP);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midramp_rst");
    m_st = S_IDLE; m_mag = 0;
    clks(2);
    rst_n = 1'b1;
    clks(6);
    set_cmd(1'b1, 12'h040);
    pwm(1, 7, 1);
    chk("resume_mag", u_if.drv_mag, 16);

    // Brake from RUN at 0x200.
    set_cmd(1'b1, 12'h200);
    ramp_to_run();
    chk("run200_mag", u_if.drv_mag, 12'h200);
    u_if.brake_lever_n = 1'b0;
    clks(2);
    chk("brk_e2_state", u_if.state, S_RUN);
    chk("brk_e2_brake_n", u_if.brake_n, 1);
    clks(1);
    chk("brk_e3_state", u_if.state, S_BRAKE);
    chk("brk_e3_brake_n", u_if.brake_n, 0);
    chk("brk_e3_mag", u_if.drv_mag, 0);
    u_if.brake_lever_n = 1'b1;
    clks(3);
    chk("brk_rel_state", u_if.state, S_IDLE);
    chk("brk_rel_brake_n", u_if.brake_n, 1);
    m_st = S_IDLE; m_mag = 0;
    settle();
    pwm(1, 7, 1);
    chk("brk_reramp_mag", u_if.drv_mag, 16);

    // Stall: hall frozen at 101 while driving 0x200.
    ramp_to_run();
    for (int i = 0; i < 6 && hidx != 0; i++) pwm(1, 7, 1);
    for (int i = 0; i < 3; i++) pwm(0, 7, 0);
    chk("stall_p3_state", u_if.state, S_RUN);
    pwm(0, 7, 0);
    chk("stall_p4_state", u_if.state, S_FAULT);
    chk("stall_fault", u_if.fault, 1);
    chk("stall_code", u_if.fault_code, 2'b01);
    chk("stall_mag", u_if.drv_mag, 0);
    chk("stall_brake_n", u_if.brake_n, 1);
    m_st = S_FAULT; m_mag = 0;
    pulse_clr();
    clks(2);
    chk("clr_en1_state", u_if.state, S_FAULT);
    u_if.brake_lever_n = 1'b0;
    clks(4);
    chk("fault_brk_state", u_if.state, S_FAULT);
    chk("fault_brk_brake_n", u_if.brake_n, 1);
    u_if.brake_lever_n = 1'b1;
    clks(3);
    set_cmd(1'b0, 12'h200);
    pulse_clr();
    chk("clr_en0_state", u_if.state, S_IDLE);
    chk("clr_en0_fault", u_if.fault, 0);
    chk("clr_en0_code", u_if.fault_code, 0);
    m_st = S_IDLE;

    // Invalid hall 111: two samples then a valid one, then three in a row.
    set_cmd(1'b1, 12'h080);
    ramp_to_run();
    for (int i = 0; i < 6 && hidx != 5; i++) pwm(1, 7, 1);
    set_hall_code(3'b111);
    pwm(0, 7, 0);
    pwm(0, 7, 0);
    clks(2);
    chk("inv2_state", u_if.state, S_RUN);
    hidx = 0;
    set_hall_code(seq[0]);
    pwm(0, 7, 0);
    clks(2);
    chk("inv2_valid_state", u_if.state, S_RUN);
    chk("inv2_valid_fault", u_if.fault, 0);
    set_hall_code(3'b111);
    pwm(0, 7, 0);
    pwm(0, 7, 0);
    chk("inv_p2_state", u_if.state, S_RUN);
    pwm(0, 7, 0);
    chk("inv_p3_state", u_if.state, S_FAULT);
    chk("inv_p3_code", u_if.fault_code, 2'b10);
    chk("inv_p3_mag", u_if.drv_mag, 0);
    m_st = S_FAULT; m_mag = 0;
    set_hall_code(seq[hidx]);
    set_cmd(1'b0, 12'h080);
    pulse_clr();
    chk("inv_clr_state", u_if.state, S_IDLE);
    m_st = S_IDLE;

    // Non-adjacent hall step 101 -> 110.
    set_cmd(1'b1, 12'h080);
    ramp_to_run();
    for (int i = 0; i < 6 && hidx != 0; i++) pwm(1, 7, 1);
    hidx = 2;
    set_hall_code(seq[2]);
    pwm(0, 7, 0);
    clks(2);
`ifdef HALL_SEQ_CHECK_EN
    chk("seq_state", u_if.state, S_FAULT);
    chk("seq_code", u_if.fault_code, 2'b11);
    set_cmd(1'b0, 12'h080);
    m_st = S_FAULT;
    pulse_clr();
    chk("seq_clr_state", u_if.state, S_IDLE);
    m_st = S_IDLE; m_mag = 0;
`else
    chk("noseq_state", u_if.state, S_RUN);
    chk("noseq_fault", u_if.fault, 0);
    pulse_clr();
    clks(2);
    chk("clr_outside_state", u_if.state, S_RUN);
    chk("clr_outside_code", u_if.fault_code, 0);
`endif

    // Randomized commands with valid hall rotation in either direction.
    for (int k = 0; k < 200; k++) begin
      if (k % 25 == 0 || $urandom_range(0, 9) == 0)
        set_cmd(($urandom_range(0, 5) != 0), $urandom_range(1, 12'h3FF));
      pwm(($urandom_range(0, 3) == 0) ? -1 : 1, $urandom_range(5, 10), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
